// File: rtl/pipeline_stall_ctrl_if.sv
// Handshake bundle between the stall controller and the pipeline it steers.
// The master side drives the hazard, branch and memory events; the slave side returns enables, flushes and counters.
interface pipeline_stall_ctrl_if #(
   parameter int CNT_W = 32
);
   logic             hazard_stall;
   logic             branch_taken;
   logic             mem_req;
   logic             mem_ready;
   logic             cnt_clear;
   logic             pc_write;
   logic             ifid_write;
   logic             ifid_flush;
   logic             idex_flush;
   logic             exmem_write;
   logic             memwb_flush;
   logic             timeout_err;
   logic [CNT_W-1:0] stall_count;
   logic [CNT_W-1:0] flush_count;

   modport master (
      output hazard_stall, branch_taken, mem_req, mem_ready, cnt_clear,
      input  pc_write, ifid_write, ifid_flush, idex_flush, exmem_write,
             memwb_flush, timeout_err, stall_count, flush_count
   );

   modport slave (
      input  hazard_stall, branch_taken, mem_req, mem_ready, cnt_clear,
      output pc_write, ifid_write, ifid_flush, idex_flush, exmem_write,
             memwb_flush, timeout_err, stall_count, flush_count
   );
endinterface

// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: merges data-hazard stalls, branch flushes
// and multi-cycle memory waits into one set of register enables, with saturating counters.
module pipeline_stall_ctrl #(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 32
) (
   input logic            clk,
   input logic            reset,
   pipeline_stall_ctrl_if.slave bus
);
   localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
   localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      ERROR    = 2'd2
   } state_t;

   state_t            state_r;
   state_t            state_nxt_s;
   logic [WAIT_W-1:0] wait_cnt_r;
   logic [WAIT_W-1:0] wait_cnt_nxt_s;
   logic              mem_stall_s;
   logic              err_s;
   logic              stall_inc_s;
   logic              flush_inc_s;
   logic              pc_write_s;
   logic              ifid_write_s;
   logic              ifid_flush_s;
   logic              idex_flush_s;
   logic              exmem_write_s;
   logic              memwb_flush_s;
   logic              timeout_r;
   logic [CNT_W-1:0]  stall_count_r;
   logic [CNT_W-1:0]  flush_count_r;

   // State register and memory wait counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r    <= RUN;
         wait_cnt_r <= {WAIT_W{1'b0}};
      end else begin
         state_r    <= state_nxt_s;
         wait_cnt_r <= wait_cnt_nxt_s;
      end
   end

   // Next-state logic plus combinational enables/flushes.
   always_comb begin
      state_nxt_s    = state_r;
      wait_cnt_nxt_s = wait_cnt_r;
      mem_stall_s    = 1'b0;
      err_s          = 1'b0;
      stall_inc_s    = 1'b0;
      flush_inc_s    = 1'b0;
      pc_write_s     = 1'b1;
      ifid_write_s   = 1'b1;
      ifid_flush_s   = 1'b0;
      idex_flush_s   = 1'b0;
      exmem_write_s  = 1'b1;
      memwb_flush_s  = 1'b0;
      if (reset) begin
         state_nxt_s    = RUN;
         wait_cnt_nxt_s = {WAIT_W{1'b0}};
         pc_write_s     = 1'b0;
         ifid_write_s   = 1'b0;
         exmem_write_s  = 1'b0;
         ifid_flush_s   = 1'b1;
         idex_flush_s   = 1'b1;
         memwb_flush_s  = 1'b1;
      end else begin
         case (state_r)
            RUN: begin
               mem_stall_s    = bus.mem_req & ~bus.mem_ready;
               wait_cnt_nxt_s = {WAIT_W{1'b0}};
               state_nxt_s    = mem_stall_s ? MEM_WAIT : RUN;
            end
            MEM_WAIT: begin
               // mem_req is deliberately ignored here: upstream holds the request.
               mem_stall_s = ~bus.mem_ready;
               if (bus.mem_ready) begin
                  state_nxt_s    = RUN;
                  wait_cnt_nxt_s = {WAIT_W{1'b0}};
               end else if (wait_cnt_r == WAIT_LAST) begin
                  state_nxt_s = ERROR;
               end else begin
                  wait_cnt_nxt_s = wait_cnt_r + WAIT_W'(1);
               end
            end
            ERROR: begin
               err_s = 1'b1;
            end
            default: begin
               state_nxt_s    = RUN;
               wait_cnt_nxt_s = {WAIT_W{1'b0}};
            end
         endcase

         if (err_s) begin
            pc_write_s    = 1'b0;
            ifid_write_s  = 1'b0;
            exmem_write_s = 1'b0;
            ifid_flush_s  = 1'b1;
            idex_flush_s  = 1'b1;
            memwb_flush_s = 1'b1;
         end else if (mem_stall_s) begin
            pc_write_s    = 1'b0;
            ifid_write_s  = 1'b0;
            exmem_write_s = 1'b0;
            memwb_flush_s = 1'b1;
            stall_inc_s   = 1'b1;
         end else if (bus.branch_taken) begin
            // The hazard-stalled instruction is flushed anyway, so no stall here.
            ifid_flush_s = 1'b1;
            idex_flush_s = 1'b1;
            flush_inc_s  = 1'b1;
         end else if (bus.hazard_stall) begin
            pc_write_s   = 1'b0;
            ifid_write_s = 1'b0;
            idex_flush_s = 1'b1;
            stall_inc_s  = 1'b1;
         end else begin
            stall_inc_s = 1'b0;
         end
      end
   end

   // Saturating performance counters and sticky timeout flag.
   always_ff @(posedge clk) begin
      if (reset) begin
         stall_count_r <= {CNT_W{1'b0}};
         flush_count_r <= {CNT_W{1'b0}};
         timeout_r     <= 1'b0;
      end else begin
         timeout_r <= (state_nxt_s == ERROR);
         if (bus.cnt_clear) begin
            stall_count_r <= {CNT_W{1'b0}};
            flush_count_r <= {CNT_W{1'b0}};
         end else begin
            if (stall_inc_s && (stall_count_r != CNT_MAX)) begin
               stall_count_r <= stall_count_r + CNT_W'(1);
            end
            if (flush_inc_s && (flush_count_r != CNT_MAX)) begin
               flush_count_r <= flush_count_r + CNT_W'(1);
            end
         end
      end
   end

   assign bus.pc_write    = pc_write_s;
   assign bus.ifid_write  = ifid_write_s;
   assign bus.ifid_flush  = ifid_flush_s;
   assign bus.idex_flush  = idex_flush_s;
   assign bus.exmem_write = exmem_write_s;
   assign bus.memwb_flush = memwb_flush_s;
   assign bus.timeout_err = timeout_r & ~reset;
   assign bus.stall_count = stall_count_r;
   assign bus.flush_count = flush_count_r;
endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Scoreboard bench for pipeline_stall_ctrl: directed test-plan sequences followed by random traffic,
// checked against a cycle-level behavioural model of the stall/flush rules.
module tb_pipeline_stall_ctrl;
   localparam int MT   = 4;
   localparam int CW   = 4;
   localparam int CMAX = (1 << CW) - 1;

   typedef struct {
      logic [5:0] en;      // {pc_write, ifid_write, ifid_flush, idex_flush, exmem_write, memwb_flush}
      logic       terr;
      bit         chk_cnt;
      int         sc;
      int         fc;
   } exp_t;

   logic clk;
   logic reset;
   pipeline_stall_ctrl_if #(.CNT_W(CW)) bus ();

   pipeline_stall_ctrl #(.MEM_TIMEOUT(MT), .CNT_W(CW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;

   // Reference model state: waiting = MEM_WAIT cycles already spent (-1 = no pending miss).
   int   waiting   = -1;
   bit   in_err    = 1'b0;
   int   m_sc      = 0;
   int   m_fc      = 0;
   bit   cnt_known = 1'b0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
      end
   endtask

   task automatic cyc(input bit rst, input bit hz, input bit br, input bit mq, input bit mr, input bit clr);
      exp_t e;
      bit   miss;
      int   s_inc;
      int   f_inc;
      @(posedge clk);
      #1;
      reset            = rst;
      bus.hazard_stall = hz;
      bus.branch_taken = br;
      bus.mem_req      = mq;
      bus.mem_ready    = mr;
      bus.cnt_clear    = clr;
      s_inc = 0;
      f_inc = 0;
      e.chk_cnt = cnt_known;
      e.sc      = m_sc;
      e.fc      = m_fc;
      e.terr    = in_err && !rst;
      if (rst) begin
         e.en = 6'b000111 ^ 6'b000000;
         e.en = 6'b001101 | 6'b000010 & 6'b000000;
         e.en = {1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      end else if (in_err) begin
         e.en = {1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      end else begin
         miss = (waiting >= 0) ? !mr : (mq && !mr);
         if (miss) begin
            e.en  = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
            s_inc = 1;
         end else if (br) begin
            e.en  = {1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
            f_inc = 1;
         end else if (hz) begin
            e.en  = {1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
            s_inc = 1;
         end else begin
            e.en  = {1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
         end
         if (!miss) waiting = -1;
         else if (waiting < 0) waiting = 0;
         else if (waiting == MT - 1) in_err = 1'b1;
         else waiting = waiting + 1;
      end
      q.push_back(e);
      if (rst) begin
         waiting   = -1;
         in_err    = 1'b0;
         m_sc      = 0;
         m_fc      = 0;
         cnt_known = 1'b1;
      end else if (clr) begin
         m_sc      = 0;
         m_fc      = 0;
         cnt_known = 1'b1;
      end else begin
         m_sc = (m_sc + s_inc > CMAX) ? CMAX : m_sc + s_inc;
         m_fc = (m_fc + f_inc > CMAX) ? CMAX : m_fc + f_inc;
      end
   endtask

   // Monitor: compares every presented cycle against the queued expectation.
   always @(negedge clk) begin
      exp_t e;
      if (q.size() > 0) begin
         e = q.pop_front();
         check("enables", int'({bus.pc_write, bus.ifid_write, bus.ifid_flush,
                                bus.idex_flush, bus.exmem_write, bus.memwb_flush}), int'(e.en));
         check("timeout_err", int'(bus.timeout_err), int'(e.terr));
         if (e.chk_cnt) begin
            check("stall_count", int'(bus.stall_count), e.sc);
            check("flush_count", int'(bus.flush_count), e.fc);
         end
      end
   end

   initial begin
      int ready_pct;
      reset            = 1'b1;
      bus.hazard_stall = 1'b0;
      bus.branch_taken = 1'b0;
      bus.mem_req      = 1'b0;
      bus.mem_ready    = 1'b0;
      bus.cnt_clear    = 1'b0;

      // Reset then idle.
      repeat (2) cyc(1, 0, 0, 0, 0, 0);
      repeat (3) cyc(0, 0, 0, 0, 0, 0);
      // Hazard only, then branch with hazard.
      repeat (2) cyc(0, 1, 0, 0, 0, 0);
      cyc(0, 1, 1, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0);
      // Miss resolved on the 4th cycle with branch throughout.
      repeat (3) cyc(0, 0, 1, 1, 0, 0);
      cyc(0, 0, 1, 1, 1, 0);
      cyc(0, 0, 0, 0, 0, 0);
      // Ready on the last permitted MEM_WAIT cycle.
      repeat (4) cyc(0, 0, 0, 1, 0, 0);
      cyc(0, 1, 0, 1, 1, 0);
      cyc(0, 0, 0, 0, 0, 0);
      // Single-cycle hit with hazard.
      cyc(0, 1, 0, 1, 1, 0);
      // Timeout, sticky error, clear in error, then reset recovery.
      repeat (8) cyc(0, 1, 1, 1, 0, 0);
      cyc(0, 0, 0, 0, 0, 1);
      cyc(0, 0, 1, 0, 0, 0);
      cyc(1, 0, 0, 0, 0, 0);
      repeat (2) cyc(0, 0, 0, 0, 0, 0);
      // Counter saturation and clear-over-increment.
      repeat (20) cyc(0, 1, 0, 0, 0, 0);
      cyc(0, 1, 0, 0, 0, 1);
      repeat (2) cyc(0, 0, 0, 0, 0, 0);
      repeat (20) cyc(0, 0, 1, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0);

      // Random traffic with phases of fast, slow and very slow memory.
      ready_pct = 70;
      for (int i = 0; i < 3000; i++) begin
         if (i % 200 == 0) begin
            case ($urandom_range(0, 2))
               0: ready_pct = 70;
               1: ready_pct = 30;
               default: ready_pct = 5;
            endcase
         end
         cyc($urandom_range(0, 99) < 2,
             $urandom_range(0, 99) < 30,
             $urandom_range(0, 99) < 20,
             $urandom_range(0, 99) < 30,
             $urandom_range(0, 99) < ready_pct,
             $urandom_range(0, 99) < 3);
      end

      repeat (2) @(negedge clk);
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain actual=%0d required=0", q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
